rggen_register_host_master: RTL and testbench
=============================================

Name: rggen_register_host_master

Overview:
- Initiator end of the register access bus. Accepts one host access at a time on a valid/ready request channel and drives it to REGISTERS register slaves.
- Collects the selected slave's ready and read data, and returns data plus status on a valid/ready response channel.
- Sits between the host bus adapter (APB/AXI-lite bridge) and the register block, replacing ad-hoc per-bridge sequencing.

Parameters:
ADDRESS_WIDTH, 16, width of byte address driven to slaves
DATA_WIDTH, 32, register data width
REGISTERS, 1, number of slaves on the bus (>=1)
TIMEOUT_CYCLES, 16, ACCESS-state cycles with a selected slave but no ready before a timeout response (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
i_host_valid  input  1  host request valid
o_host_ready  output  1  request accepted when valid&ready
i_host_address  input  ADDRESS_WIDTH  access address
i_host_write  input  1  1=write, 0=read
i_host_write_data  input  DATA_WIDTH  write data
i_host_write_mask  input  DATA_WIDTH  per-bit write enable
o_response_valid  output  1  response valid
i_response_ready  input  1  response consumed when valid&ready
o_response_read_data  output  DATA_WIDTH  read data; 0 for writes and errors
o_response_status  output  2  00 OK, 10 decode error, 11 timeout
o_reg_request  output  1  access request to slaves
o_reg_address  output  ADDRESS_WIDTH  latched address
o_reg_write  output  1  latched direction
o_reg_write_data  output  DATA_WIDTH  latched write data
o_reg_write_mask  output  DATA_WIDTH  latched mask
i_reg_select  input  REGISTERS  per-slave address/index match
i_reg_ready  input  REGISTERS  per-slave access complete
i_reg_read_data  input  REGISTERS*DATA_WIDTH  slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: state IDLE, counter 0, all o_reg_* 0, o_response_valid 0, o_response_read_data 0, o_response_status 00. o_host_ready = (state==IDLE) & !rst, so it is 0 while rst is high.
- FSM IDLE -> ACCESS -> RESPONSE -> IDLE.
- IDLE: o_host_ready=1. On i_host_valid at edge N: latch address/write/data/mask into o_reg_* and go to ACCESS. o_reg_request=1 from cycle N+1.
- ACCESS: o_host_ready=0. o_reg_request and all o_reg_* stay stable. Priority each cycle:
  1. i_reg_select==0 -> status 10, data 0, go RESPONSE.
  2. more than one select bit set -> status 10, data 0, go RESPONSE.
  3. single select bit k with i_reg_ready[k]=1 -> status 00; data = slave k read data if read, 0 if write; go RESPONSE.
  4. otherwise counter++. When counter==TIMEOUT_CYCLES-1 and still not ready -> status 11, data 0, go RESPONSE.
  - i_reg_ready from unselected slaves is ignored.
- Every ACCESS exit: o_reg_request=0 and counter=0 at the same edge.
- RESPONSE: o_response_valid=1, with data/status registered and held until valid&i_response_ready. Then go IDLE; o_response_valid=0 next cycle and data/status hold their last value.
- Latency: accept at edge N, slave ready in cycle N+1 -> response valid in cycle N+2. Minimum 3 cycles per transaction, one transaction outstanding.
- Timeout: request observed for exactly TIMEOUT_CYCLES cycles before the response. TIMEOUT_CYCLES=1 times out after the first non-ready cycle.
- Host-side inputs are ignored outside IDLE. No request is dropped: the host holds valid until it sees ready.
- Reset mid-ACCESS or mid-RESPONSE: abandon the transaction. All outputs return to reset values at the reset edge and no response is issued.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> o_host_ready=0, o_reg_request=0, o_response_valid=0. After release, o_host_ready=1.
- Read hit, REGISTERS=2: read 0x0010, select=01, ready=01 immediately, slave0 data=0xDEADBEEF -> o_reg_request high exactly 1 cycle, response valid 2 cycles after accept, data 0xDEADBEEF, status 00.
- Write with wait states: write 0x0004, data 0x12345678, mask 0x0000FFFF, select=10, ready[1] asserted on the 4th ACCESS cycle -> o_reg_* stable for 4 cycles, response data 0, status 00.
- Decode error: select=00 -> o_reg_request 1 cycle, status 10, data 0. Repeat with select=11 -> status 10.
- Timeout, TIMEOUT_CYCLES=4: select=01, ready never -> request high 4 cycles, status 11. Back-pressure with i_response_ready=0 for 3 cycles -> valid/data/status held, o_host_ready stays 0 until the handshake.
- Reset during ACCESS: assert rst in the 2nd wait cycle -> o_reg_request=0 after that edge, no response. A new request after reset completes normally.

Source files
------------

// File: rtl/rggen_register_host_master.sv
// Register-bus initiator: takes one host access on a valid/ready request channel, runs it
// against REGISTERS slaves and returns read data plus status on a valid/ready response channel.
module rggen_register_host_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_host_valid,
    output logic                            o_host_ready,
    input  logic [ADDRESS_WIDTH-1:0]        i_host_address,
    input  logic                            i_host_write,
    input  logic [DATA_WIDTH-1:0]           i_host_write_data,
    input  logic [DATA_WIDTH-1:0]           i_host_write_mask,
    output logic                            o_response_valid,
    input  logic                            i_response_ready,
    output logic [DATA_WIDTH-1:0]           o_response_read_data,
    output logic [1:0]                      o_response_status,
    output logic                            o_reg_request,
    output logic [ADDRESS_WIDTH-1:0]        o_reg_address,
    output logic                            o_reg_write,
    output logic [DATA_WIDTH-1:0]           o_reg_write_data,
    output logic [DATA_WIDTH-1:0]           o_reg_write_mask,
    input  logic [REGISTERS-1:0]            i_reg_select,
    input  logic [REGISTERS-1:0]            i_reg_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_reg_read_data
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_DECODE  = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;

    logic                    sel_any;
    logic                    sel_multi;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_data;

    logic                    access_done;
    logic [1:0]              access_status;
    logic [DATA_WIDTH-1:0]   access_data;

    assign o_host_ready = (state == IDLE) && !rst;

    // Ready and read data of unselected slaves are masked out before they reach the FSM.
    always_comb begin
        sel_any   = 1'b0;
        sel_multi = 1'b0;
        sel_ready = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_reg_select[k]) begin
                if (sel_any) begin
                    sel_multi = 1'b1;
                end
                sel_any   = 1'b1;
                sel_ready = sel_ready | i_reg_ready[k];
                sel_data  = sel_data | i_reg_read_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        access_done   = 1'b0;
        access_status = STATUS_OK;
        access_data   = '0;
        if (!sel_any || sel_multi) begin
            access_done   = 1'b1;
            access_status = STATUS_DECODE;
        end else if (sel_ready) begin
            access_done   = 1'b1;
            access_status = STATUS_OK;
            access_data   = o_reg_write ? '0 : sel_data;
        end else if (count == CNT_LAST) begin
            access_done   = 1'b1;
            access_status = STATUS_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            count                <= '0;
            o_reg_request        <= 1'b0;
            o_reg_address        <= '0;
            o_reg_write          <= 1'b0;
            o_reg_write_data     <= '0;
            o_reg_write_mask     <= '0;
            o_response_valid     <= 1'b0;
            o_response_read_data <= '0;
            o_response_status    <= STATUS_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (i_host_valid) begin
                        o_reg_request    <= 1'b1;
                        o_reg_address    <= i_host_address;
                        o_reg_write      <= i_host_write;
                        o_reg_write_data <= i_host_write_data;
                        o_reg_write_mask <= i_host_write_mask;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (access_done) begin
                        o_reg_request        <= 1'b0;
                        count                <= '0;
                        o_response_valid     <= 1'b1;
                        o_response_status    <= access_status;
                        o_response_read_data <= access_data;
                        state                <= RESPONSE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RESPONSE: begin
                    // Data and status keep their last value after the handshake.
                    if (i_response_ready) begin
                        o_response_valid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_register_host_master.sv
// Scoreboard bench for rggen_register_host_master with two slaves and a 4-cycle timeout.
module tb_rggen_register_host_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_host_valid;
    logic            o_host_ready;
    logic [AW-1:0]   i_host_address;
    logic            i_host_write;
    logic [DW-1:0]   i_host_write_data;
    logic [DW-1:0]   i_host_write_mask;
    logic            o_response_valid;
    logic            i_response_ready;
    logic [DW-1:0]   o_response_read_data;
    logic [1:0]      o_response_status;
    logic            o_reg_request;
    logic [AW-1:0]   o_reg_address;
    logic            o_reg_write;
    logic [DW-1:0]   o_reg_write_data;
    logic [DW-1:0]   o_reg_write_mask;
    logic [NR-1:0]   i_reg_select;
    logic [NR-1:0]   i_reg_ready;
    logic [NR*DW-1:0] i_reg_read_data;

    typedef struct packed {
        logic [1:0]    status;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_register_host_master #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .REGISTERS      (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_host_valid         (i_host_valid),
        .o_host_ready         (o_host_ready),
        .i_host_address       (i_host_address),
        .i_host_write         (i_host_write),
        .i_host_write_data    (i_host_write_data),
        .i_host_write_mask    (i_host_write_mask),
        .o_response_valid     (o_response_valid),
        .i_response_ready     (i_response_ready),
        .o_response_read_data (o_response_read_data),
        .o_response_status    (o_response_status),
        .o_reg_request        (o_reg_request),
        .o_reg_address        (o_reg_address),
        .o_reg_write          (o_reg_write),
        .o_reg_write_data     (o_reg_write_data),
        .o_reg_write_mask     (o_reg_write_mask),
        .i_reg_select         (i_reg_select),
        .i_reg_ready          (i_reg_ready),
        .i_reg_read_data      (i_reg_read_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1);
    end

    // One full transaction; rdy_cycle is the 1-based ACCESS cycle where ready rises (0 = never).
    // Before that the unselected slaves assert ready, which must be ignored.
    task automatic do_access(input string name, input logic [AW-1:0] addr, input logic wr,
                             input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                             input logic [1:0] sel, input int rdy_cycle,
                             input logic [DW-1:0] rd0, input logic [DW-1:0] rd1,
                             input int exp_req, input int stall);
        resp_t e;
        resp_t got;
        int    cyc;
        if (sel == 2'b00 || sel == 2'b11)       e = '{status: 2'b10, data: '0};
        else if (rdy_cycle == 0 || rdy_cycle > TO) e = '{status: 2'b11, data: '0};
        else if (wr)                            e = '{status: 2'b00, data: '0};
        else                                    e = '{status: 2'b00, data: (sel[0] ? rd0 : rd1)};
        exp_q.push_back(e);

        i_host_address    = addr;
        i_host_write      = wr;
        i_host_write_data = wd;
        i_host_write_mask = wm;
        i_host_valid      = 1'b1;
        i_reg_select      = sel;
        i_reg_ready       = ~sel;
        i_reg_read_data   = {rd1, rd0};
        #1;
        checks++;
        if (o_host_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s host_ready_idle: actual=%b required=1", name, o_host_ready);
        end
        @(posedge clk);
        @(negedge clk);
        // Garbage on the host side while busy must not disturb the latched access.
        i_host_valid      = 1'b0;
        i_host_address    = ~addr;
        i_host_write      = ~wr;
        i_host_write_data = ~wd;
        i_host_write_mask = ~wm;
        cyc = 0;
        while (o_reg_request === 1'b1 && cyc < 20) begin
            cyc++;
            checks++;
            if ({o_reg_address, o_reg_write, o_reg_write_data, o_reg_write_mask} !== {addr, wr, wd, wm}) begin
                failures++;
                $display("FAIL %s reg_stable cyc%0d: actual=%h/%b/%h/%h required=%h/%b/%h/%h", name, cyc,
                         o_reg_address, o_reg_write, o_reg_write_data, o_reg_write_mask, addr, wr, wd, wm);
            end
            checks++;
            if (o_host_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s host_ready_busy cyc%0d: actual=%b required=0", name, cyc, o_host_ready);
            end
            i_reg_ready = (cyc == rdy_cycle) ? 2'b11 : ~sel;
            @(posedge clk);
            @(negedge clk);
        end
        i_reg_ready  = '0;
        i_reg_select = '0;
        checks++;
        if (cyc !== exp_req) begin
            failures++;
            $display("FAIL %s request_cycles: actual=%0d required=%0d", name, cyc, exp_req);
        end

        i_response_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            checks++;
            if (o_response_valid !== 1'b1 || o_host_ready !== 1'b0 ||
                {o_response_status, o_response_read_data} !== e) begin
                failures++;
                $display("FAIL %s stall%0d: actual valid=%b ready=%b st=%b d=%h required valid=1 ready=0 st=%b d=%h",
                         name, s, o_response_valid, o_host_ready, o_response_status, o_response_read_data,
                         e.status, e.data);
            end
            @(posedge clk);
            @(negedge clk);
        end

        checks++;
        if (o_response_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s response_valid: actual=%b required=1", name, o_response_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard: actual=empty required=entry", name);
            got = '0;
        end else begin
            got = exp_q.pop_front();
            if ({o_response_status, o_response_read_data} !== got) begin
                failures++;
                $display("FAIL %s response: actual st=%b d=%h required st=%b d=%h", name,
                         o_response_status, o_response_read_data, got.status, got.data);
            end
        end
        i_response_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_response_ready = 1'b0;
        #1;
        checks++;
        if (o_response_valid !== 1'b0 || o_host_ready !== 1'b1 ||
            {o_response_status, o_response_read_data} !== got) begin
            failures++;
            $display("FAIL %s after_handshake: actual valid=%b ready=%b st=%b d=%h required valid=0 ready=1 st=%b d=%h",
                     name, o_response_valid, o_host_ready, o_response_status, o_response_read_data,
                     got.status, got.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        i_host_valid      = 1'b0;
        i_host_address    = '0;
        i_host_write      = 1'b0;
        i_host_write_data = '0;
        i_host_write_mask = '0;
        i_response_ready  = 1'b0;
        i_reg_select      = '0;
        i_reg_ready       = '0;
        i_reg_read_data   = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (o_host_ready !== 1'b0 || o_reg_request !== 1'b0 || o_response_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc%0d: actual ready=%b req=%b valid=%b required 0/0/0",
                         i, o_host_ready, o_reg_request, o_response_valid);
            end
        end
        checks++;
        if (o_reg_address !== '0 || o_reg_write !== 1'b0 || o_reg_write_data !== '0 ||
            o_reg_write_mask !== '0 || o_response_read_data !== '0 || o_response_status !== 2'b00) begin
            failures++;
            $display("FAIL reset_values: actual addr=%h wr=%b wd=%h wm=%h rd=%h st=%b required all zero",
                     o_reg_address, o_reg_write, o_reg_write_data, o_reg_write_mask,
                     o_response_read_data, o_response_status);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_host_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: actual=%b required=1", o_host_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        do_access("read_hit", 16'h0010, 1'b0, 32'h0, 32'h0, 2'b01, 1, 32'hDEADBEEF, 32'h0BADF00D, 1, 0);
        do_access("read_slave1", 16'h0020, 1'b0, 32'h0, 32'h0, 2'b10, 2, 32'h11111111, 32'hCAFEF00D, 2, 0);
    endtask

    task automatic test_write_wait();
        do_access("write_wait", 16'h0004, 1'b1, 32'h12345678, 32'h0000FFFF, 2'b10, 4,
                  32'hAAAA5555, 32'h5555AAAA, 4, 0);
    endtask

    task automatic test_decode_error();
        do_access("decode_none", 16'h0100, 1'b0, 32'h0, 32'h0, 2'b00, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        do_access("decode_multi", 16'h0104, 1'b1, 32'hA5A5A5A5, 32'hFFFFFFFF, 2'b11, 1,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    endtask

    task automatic test_timeout_backpressure();
        do_access("timeout", 16'h0200, 1'b0, 32'h0, 32'h0, 2'b01, 0, 32'h76543210, 32'h0, 4, 3);
    endtask

    task automatic test_reset_mid_access();
        i_host_address    = 16'h0300;
        i_host_write      = 1'b1;
        i_host_write_data = 32'h0F0F0F0F;
        i_host_write_mask = 32'hFFFFFFFF;
        i_host_valid      = 1'b1;
        i_reg_select      = 2'b01;
        i_reg_ready       = 2'b00;
        @(posedge clk);
        @(negedge clk);
        i_host_valid = 1'b0;
        checks++;
        if (o_reg_request !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid request_started: actual=%b required=1", o_reg_request);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_reg_select = '0;
        checks++;
        if (o_reg_request !== 1'b0 || o_response_valid !== 1'b0 || o_host_ready !== 1'b0 ||
            o_reg_address !== '0 || o_reg_write_data !== '0) begin
            failures++;
            $display("FAIL rst_mid abandon: actual req=%b valid=%b ready=%b addr=%h wd=%h required 0/0/0/0/0",
                     o_reg_request, o_response_valid, o_host_ready, o_reg_address, o_reg_write_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (o_response_valid !== 1'b0 || o_host_ready !== 1'b1 || o_reg_request !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid quiet%0d: actual valid=%b ready=%b req=%b required 0/1/0",
                         i, o_response_valid, o_host_ready, o_reg_request);
            end
        end
        // A fresh timeout also proves the wait counter was cleared by the reset.
        do_access("after_rst_timeout", 16'h0304, 1'b0, 32'h0, 32'h0, 2'b10, 0, 32'h0, 32'h13572468, 4, 0);
        do_access("after_rst_read", 16'h0308, 1'b0, 32'h0, 32'h0, 2'b10, 3, 32'h0, 32'h2468ACE0, 3, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            logic [DW-1:0] rd;
            rd = $urandom();
            do_access("b2b", AW'(16'h0400 + 4 * i), 1'b0, 32'h0, 32'h0, 2'b01, 1, rd, ~rd, 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_wait();
        test_decode_error();
        test_timeout_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
